// File: rtl/kcore_write_back_packer_if.sv
// kcore_write_back_packer_if: start-token FIFO, value FIFO, write channel and status of the packer.
// Rev 1.0
`default_nettype none

interface kcore_write_back_packer_if #(
  parameter int VAL_WIDTH  = 32,
  parameter int PACK       = 16,
  parameter int LEN_WIDTH  = 32,
  parameter int ADDR_WIDTH = 64
);
  logic                          start_empty_n;
  logic                          start_read;
  logic [ADDR_WIDTH-1:0]         job_base_addr;
  logic [LEN_WIDTH-1:0]          job_num_vertices;
  logic                          val_empty_n;
  logic                          val_read;
  logic [VAL_WIDTH-1:0]          val_dout;
  logic                          wr_valid;
  logic                          wr_ready;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [VAL_WIDTH*PACK-1:0]     wr_data;
  logic [VAL_WIDTH*PACK/8-1:0]   wr_strb;
  logic                          busy;
  logic                          done;

  modport master (
    input  start_empty_n, job_base_addr, job_num_vertices, val_empty_n, val_dout, wr_ready,
    output start_read, val_read, wr_valid, wr_addr, wr_data, wr_strb, busy, done
  );

  modport slave (
    output start_empty_n, job_base_addr, job_num_vertices, val_empty_n, val_dout, wr_ready,
    input  start_read, val_read, wr_valid, wr_addr, wr_data, wr_strb, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/kcore_write_back_packer.sv
// kcore_write_back_packer: packs a job's core values into PACK-lane write beats at sequential addresses.
// Rev 1.0
`default_nettype none

module kcore_write_back_packer #(
  parameter int VAL_WIDTH  = 32,
  parameter int PACK       = 16,
  parameter int LEN_WIDTH  = 32,
  parameter int ADDR_WIDTH = 64
) (
  input  logic clk,
  input  logic reset_n,
  kcore_write_back_packer_if.master bus
);
  localparam int c_slot_w     = $clog2(PACK) + 1;
  localparam int c_lane_w     = $clog2(PACK);
  localparam int c_lane_bytes = VAL_WIDTH / 8;
  localparam int c_beat_bytes = PACK * VAL_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                              r_state;
  logic [ADDR_WIDTH-1:0]               r_addr;
  logic [LEN_WIDTH-1:0]                r_remaining;
  logic [c_slot_w-1:0]                 r_slot;
  logic [PACK-1:0][VAL_WIDTH-1:0]      r_lanes;
  logic [VAL_WIDTH*PACK/8-1:0]         w_strb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_slot      <= '0;
      r_lanes     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_empty_n) begin
            r_addr      <= bus.job_base_addr;
            r_remaining <= bus.job_num_vertices;
            r_slot      <= '0;
            r_state     <= (bus.job_num_vertices == '0) ? DONE : FILL;
          end
        end
        FILL: begin
          if (bus.val_empty_n) begin
            r_lanes[r_slot[c_lane_w-1:0]] <= bus.val_dout;
            r_slot      <= r_slot + c_slot_w'(1);
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            // Leave on the pop that fills the last lane or consumes the last value.
            if (r_slot == c_slot_w'(PACK - 1) || r_remaining == LEN_WIDTH'(1)) begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.wr_ready) begin
            r_addr  <= r_addr + ADDR_WIDTH'(c_beat_bytes);
            r_slot  <= '0;
            r_lanes <= '0;
            r_state <= (r_remaining == '0) ? DONE : FILL;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobe covers exactly the filled lanes; zero outside ISSUE.
  for (genvar i = 0; i < PACK; i++) begin : g_strb
    assign w_strb[i*c_lane_bytes +: c_lane_bytes] =
      {c_lane_bytes{(r_state == ISSUE) && (r_slot > c_slot_w'(i))}};
  end

  // reset_n gates start_read because IDLE is also the in-reset state.
  assign bus.start_read = reset_n && (r_state == IDLE) && bus.start_empty_n;
  assign bus.val_read   = (r_state == FILL) && bus.val_empty_n;
  assign bus.wr_valid   = (r_state == ISSUE);
  assign bus.wr_addr    = r_addr;
  assign bus.wr_data    = r_lanes;
  assign bus.wr_strb    = w_strb;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_kcore_write_back_packer.sv
// tb_kcore_write_back_packer: directed jobs against a beat-level model of the packer.
// Rev 1.0
`default_nettype none

module tb_kcore_write_back_packer;
  localparam int VW = 32;
  localparam int PK = 16;
  localparam int LW = 32;
  localparam int AW = 64;
  localparam int DW = VW * PK;
  localparam int SB = DW / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  kcore_write_back_packer_if #(.VAL_WIDTH(VW), .PACK(PK), .LEN_WIDTH(LW), .ADDR_WIDTH(AW)) bus();

  kcore_write_back_packer #(.VAL_WIDTH(VW), .PACK(PK), .LEN_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SB-1:0] strb;
    bit            last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] n;
  } tok_t;

  beat_t         exp_q[$];
  beat_t         acc_log[$];
  tok_t          tok_q[$];
  logic [VW-1:0] val_q[$];
  int            pop_log[$];
  int            done_log[$];
  int            first_valid[$];

  int  n_assert = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  stall_left = 0;
  int  stall_seen = 0;
  int  vpops = 0;
  int  sr_count = 0;
  bit  in_job = 0;
  bit  done_due = 0;
  bit  prev_stall = 0;
  bit  rand_mode = 0;
  bit  want_first = 0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [SB-1:0] p_strb;
  logic [DW-1:0] d;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_job(input logic [AW-1:0] base, input int n, input int first);
    tok_t  t;
    beat_t b;
    t.base = base;
    t.n    = LW'(n);
    tok_q.push_back(t);
    for (int i = 0; i < n; i++) val_q.push_back(VW'(first + i));
    for (int k = 0; k * PK < n; k++) begin
      b.addr = base + AW'(k * PK * VW / 8);
      b.data = '0;
      b.strb = '0;
      for (int l = 0; l < PK; l++) begin
        if (k * PK + l < n) begin
          b.data[l*VW +: VW]         = VW'(first + k * PK + l);
          b.strb[l*(VW/8) +: (VW/8)] = '1;
        end
      end
      b.last = ((k + 1) * PK >= n);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_inputs();
    bit en;
    bus.start_empty_n    = (tok_q.size() != 0);
    bus.job_base_addr    = (tok_q.size() != 0) ? tok_q[0].base : '0;
    bus.job_num_vertices = (tok_q.size() != 0) ? tok_q[0].n : '0;
    en = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    bus.val_empty_n      = en && (val_q.size() != 0);
    bus.val_dout         = (val_q.size() != 0) ? val_q[0] : '0;
    bus.wr_ready         = (stall_left == 0);
  endtask

  // One cycle: drive, compare against the model, advance the model, cross the clock edge.
  task automatic tick();
    bit    sr_exp;
    bit    nd;
    beat_t e;
    tok_t  t;
    drive_inputs();
    #1;
    sr_exp = bus.start_empty_n && !in_job;
    nd = 1'b0;
    chk("busy", bus.busy, in_job);
    chk("done", bus.done, done_due);
    chk("start_read", bus.start_read, sr_exp);
    chk("val_read_gate", bus.val_read && !(bus.val_empty_n && in_job && !done_due && !bus.wr_valid), 1'b0);
    if (prev_stall) begin
      chk("hold_valid", bus.wr_valid, 1'b1);
      chk("hold_addr", bus.wr_addr, p_addr);
      chk("hold_data", bus.wr_data, p_data);
      chk("hold_strb", bus.wr_strb, p_strb);
    end
    if (bus.wr_valid && want_first) begin
      first_valid.push_back(cyc);
      want_first = 0;
    end
    if (bus.wr_valid && bus.wr_ready) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat at %0h expected no beat", bus.wr_addr);
      end else begin
        e = exp_q.pop_front();
        chk("beat_addr", bus.wr_addr, e.addr);
        chk("beat_data", bus.wr_data, e.data);
        chk("beat_strb", bus.wr_strb, e.strb);
        nd = e.last;
      end
      e.addr = bus.wr_addr;
      e.data = bus.wr_data;
      e.strb = bus.wr_strb;
      acc_log.push_back(e);
    end
    if (bus.wr_valid && !bus.wr_ready) stall_seen++;
    if (bus.done) done_log.push_back(cyc);
    if (done_due) in_job = 0;
    if (sr_exp && tok_q.size() != 0) begin
      t = tok_q.pop_front();
      in_job = 1;
      sr_count++;
      pop_log.push_back(cyc);
      want_first = 1;
      if (t.n == '0) nd = 1'b1;
    end
    if (bus.val_read && val_q.size() != 0) begin
      void'(val_q.pop_front());
      vpops++;
    end
    if (bus.wr_valid && stall_left > 0) stall_left--;
    prev_stall = bus.wr_valid && !bus.wr_ready;
    p_addr = bus.wr_addr;
    p_data = bus.wr_data;
    p_strb = bus.wr_strb;
    done_due = nd;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while ((in_job || done_due || tok_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      n_assert++;
      n_fail++;
      $display("FAIL timeout: got still busy after %0d cycles expected idle", budget);
    end
    tick();
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pop_log.delete();
    done_log.delete();
    first_valid.delete();
    sr_count = 0;
    stall_seen = 0;
    vpops = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start_read"}, bus.start_read, 1'b0);
    chk({tag, "_val_read"}, bus.val_read, 1'b0);
    chk({tag, "_wr_valid"}, bus.wr_valid, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_wr_addr"}, bus.wr_addr, '0);
    chk({tag, "_wr_data"}, bus.wr_data, '0);
    chk({tag, "_wr_strb"}, bus.wr_strb, '0);
  endtask

  initial begin
    drive_inputs();
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Zero-length job
    clear_logs();
    add_job(64'h500, 0, 0);
    run_until_idle(20);
    chk("zero_sr_cycles", sr_count, 1);
    chk("zero_no_beats", acc_log.size(), 0);
    if (pop_log.size() == 1 && done_log.size() == 1) chk("zero_done_at_T1", done_log[0] - pop_log[0], 1);
    else chk("zero_logs", pop_log.size() + done_log.size(), 2);

    // Full single beat
    clear_logs();
    add_job(64'h1000, 16, 0);
    run_until_idle(100);
    chk("full_beats", acc_log.size(), 1);
    if (acc_log.size() >= 1) begin
      d = acc_log[0].data;
      chk("full_addr", acc_log[0].addr, 64'h1000);
      chk("full_lane5", d[5*VW +: VW], 5);
      chk("full_lane15", d[15*VW +: VW], 15);
      chk("full_strb", acc_log[0].strb, {SB{1'b1}});
    end
    if (first_valid.size() >= 1) chk("first_beat_latency", first_valid[0] - pop_log[0], PK + 1);

    // Partial last beat
    clear_logs();
    add_job(64'h1000, 20, 0);
    run_until_idle(100);
    chk("partial_beats", acc_log.size(), 2);
    if (acc_log.size() >= 2) begin
      d = acc_log[1].data;
      chk("partial_addr", acc_log[1].addr, 64'h1040);
      chk("partial_lane3", d[3*VW +: VW], 19);
      chk("partial_lane4", d[4*VW +: VW], 0);
      chk("partial_strb", acc_log[1].strb, 64'hFFFF);
    end

    // Backpressure for 10 cycles in ISSUE
    clear_logs();
    stall_left = 10;
    add_job(64'h2000, 16, 100);
    run_until_idle(100);
    chk("stall_cycles", stall_seen, 10);
    chk("stall_beats", acc_log.size(), 1);

    // Token while busy, random value-FIFO stalls, address wrap
    clear_logs();
    rand_mode = 1;
    add_job(64'h4000, 20, 200);
    add_job(64'h5000, 5, 300);
    add_job(64'hFFFF_FFFF_FFFF_FFC0, 20, 400);
    run_until_idle(600);
    rand_mode = 0;
    chk("busy_tokens", sr_count, 3);
    if (pop_log.size() >= 2 && done_log.size() >= 1) chk("second_job_start", pop_log[1] - done_log[0], 1);
    if (acc_log.size() >= 5) chk("wrap_addr", acc_log[4].addr, 64'h0);
    chk("values_consumed", val_q.size(), 0);

    // Reset in the middle of FILL
    clear_logs();
    add_job(64'h3000, 20, 500);
    for (int k = 0; k < 100 && vpops < 5; k++) tick();
    chk("abort_pops", vpops, 5);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    val_q.delete();
    exp_q.delete();
    in_job = 0;
    done_due = 0;
    prev_stall = 0;
    want_first = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("abort_no_beat", acc_log.size(), 0);
    add_job(64'h6000, 3, 700);
    run_until_idle(100);
    chk("recover_beats", acc_log.size(), 1);
    if (acc_log.size() >= 1) chk("recover_strb", acc_log[0].strb, 64'hFFF);
    chk("expected_beats_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kcore_write_back_packer.md
# kcore_write_back_packer

Dataflow write-back stage of the k-core kernel. Waits for a start token from the upstream 1-bit start-token FIFO, then drains a stream of per-vertex core values from a value FIFO. It packs the values into wide memory beats and issues them as sequential write requests starting at a job base address. When the job completes it pulses `done` and returns to idle to wait for the next token.

## Interface

Parameters:
- `VAL_WIDTH`, 32: bits per core value.
- `PACK`, 16: values per write beat. Power of two, ≥2.
- `LEN_WIDTH`, 32: width of the vertex count.
- `ADDR_WIDTH`, 64: byte-address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_empty_n`  in  1  start-token FIFO has a token.
- `start_read`  out  1  pop the start token.
- `job_base_addr`  in  ADDR_WIDTH  byte address of the first beat; sampled on token pop.
- `job_num_vertices`  in  LEN_WIDTH  number of values in the job; sampled on token pop.
- `val_empty_n`  in  1  value FIFO non-empty.
- `val_read`  out  1  pop the value FIFO.
- `val_dout`  in  VAL_WIDTH  head of the value FIFO.
- `wr_valid`  out  1  write beat valid.
- `wr_ready`  in  1  memory accepts the beat.
- `wr_addr`  out  ADDR_WIDTH  beat byte address.
- `wr_data`  out  VAL_WIDTH*PACK  packed values; lane i = bits [i*VAL_WIDTH +: VAL_WIDTH].
- `wr_strb`  out  VAL_WIDTH*PACK/8  byte enables.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at job end.

## Operation

- FSM states: IDLE, FILL, ISSUE, DONE.
- **IDLE**
  - `start_read = start_empty_n`, combinational.
  - On a pop, latch `addr ← job_base_addr`, `remaining ← job_num_vertices` and `slot ← 0`.
  - If `job_num_vertices == 0`, go to DONE; otherwise go to FILL.
- **FILL**
  - `val_read = val_empty_n`.
  - On each pop, write `val_dout` into lane `slot`, then `slot++` and `remaining--`.
  - Go to ISSUE after the pop that makes `slot == PACK` or `remaining == 0`.
  - If `val_empty_n` is low, stay in FILL with no timeout.
- **ISSUE**
  - `wr_valid = 1`. `wr_strb` has bytes [0, slot*VAL_WIDTH/8) set and the rest zero.
  - Unfilled lanes of `wr_data` are zero; lanes are cleared when the beat is accepted.
  - On `wr_valid & wr_ready`: `addr += PACK*VAL_WIDTH/8`, `slot ← 0`.
  - Then go to DONE if `remaining == 0`, otherwise to FILL.
- **DONE**
  - `done = 1` for one cycle, then go to IDLE.
- Width and arithmetic rules:
  - `addr` wraps modulo 2^ADDR_WIDTH.
  - `remaining` never underflows, because pops are gated by the state.
  - `slot` is log2(PACK)+1 bits wide.
- `start_read` and `val_read` are never high outside IDLE and FILL respectively.
- Only one job is in flight at a time. A token arriving while `busy` waits in the FIFO, untouched.

## Timing

- Reset (`reset_n` low) takes effect asynchronously, at any time:
  - state goes to IDLE;
  - `start_read`, `val_read`, `wr_valid`, `busy`, `done`, `wr_addr`, `wr_data` and `wr_strb` all go to 0.
- Reset mid-job abandons the job: an unaccepted beat is dropped and the consumed token is not replayed.
- Token popped in cycle T:
  - FILL runs from T+1, and the first value pop is possible in T+1.
  - With a value available every cycle, the first beat is valid in cycle T+1+PACK.
- Each beat costs at least one ISSUE cycle. Sustained throughput is PACK values per PACK+1 cycles.
- While `wr_valid & !wr_ready`, `wr_addr`, `wr_data` and `wr_strb` are held stable and `val_read` stays 0.
- `done` is asserted in the cycle after the final accepted beat.
- For a zero-length job, `done` is asserted at T+1.
- `busy` rises at T+1 and falls with the exit from DONE, so it is 0 in the cycle after `done`.

## Test plan

- Zero-length job: token with `job_num_vertices = 0` → `start_read` high for 1 cycle, `wr_valid` never asserted, `done` pulses at T+1.
- Full single beat (defaults): base 0x1000, 16 values 0..15 → one beat with `wr_addr = 0x1000`, lane i = i, `wr_strb` all ones (64 bits), then `done`.
- Partial last beat: 20 values 0..19, base 0x1000 →
  - beat 1 at 0x1000, full strobe;
  - beat 2 at 0x1040 with lanes 0..3 = 16..19, lanes 4..15 = 0, `wr_strb = 0x000…FFFF` (16 bytes).
- Backpressure: hold `wr_ready = 0` for 10 cycles during ISSUE → `wr_valid` stays 1, outputs bit-stable, `val_read = 0`. Beat accepted on the first ready cycle.
- Token while busy, plus FIFO stalls: second token present during job 1, and `val_empty_n` toggled randomly → `start_read` stays 0 until IDLE, all values are packed in order, and the second job starts one cycle after `done`.
- Reset mid-FILL: assert `reset_n = 0` after 5 pops → all outputs 0 immediately. After release the block sits in IDLE and requires a new token, and no beat is issued for the aborted job.
